// File: rtl/bcd_pkg.sv
// +--------------------------------------------------------------------+
// | bcd_pkg: shared types and constants for the sequential BCD converter|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int               DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // Smallest digit count d such that 10^d > 2^bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    longint unsigned pow10;
    int              d;
    max_val = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
    pow10   = 64'd1;
    d       = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// +--------------------------------------------------------------------+
// | bcd_digit_adj: double-dabble digit correction (add 3 when >= 5)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_bin_to_bcd.sv
// +--------------------------------------------------------------------+
// | seq_bin_to_bcd: one-bit-per-cycle double-dabble binary to BCD      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          binary,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      neg
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_too_small
    $error("seq_bin_to_bcd: DIGITS too small to hold 2^BIN_W-1");
  end

  state_e           state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             neg_pend_q, neg_pend_d;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic                   neg_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjust first, then shift the accumulator and shift register as one word.
  assign shifted = {acc_adj, sr_q} << 1;
  assign neg_in  = (SIGNED != 0) && binary[BIN_W-1];

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign neg       = neg_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    neg_pend_d = neg_pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d       = neg_in ? ((~binary) + BIN_W'(1)) : binary;
          neg_pend_d = neg_in;
          acc_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = shifted[ACC_W+BIN_W-1:BIN_W];
        sr_d  = shifted[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[ACC_W+BIN_W-1:BIN_W];
          neg_d   = neg_pend_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      neg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      neg_pend_q <= neg_pend_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_bin_to_bcd.sv
// +--------------------------------------------------------------------+
// | tb_seq_bin_to_bcd: directed and back-to-back checks of the converter|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seq_bin_to_bcd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration: 16-bit, 5 digits, unsigned
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_neg;
  logic [15:0] a_bin;
  logic [19:0] a_bcd;
  // 8-bit, 3 digits, unsigned
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_neg;
  logic [7:0]  b_bin;
  logic [11:0] b_bcd;
  // 8-bit, 3 digits, signed
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_neg;
  logic [7:0]  c_bin;
  logic [11:0] c_bcd;

  seq_bin_to_bcd u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .binary(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd(a_bcd), .neg(a_neg)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .binary(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .neg(b_neg)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .binary(c_bin),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .bcd(c_bcd), .neg(c_neg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic run_a(input string tag, input logic [15:0] v, input logic [19:0] exp);
    int cyc;
    a_bin = v; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_bin = ~v;
    cyc = 0;
    while (!a_out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, "_lat"}, cyc, 16);
    check({tag, "_bcd"}, a_bcd, exp);
    check({tag, "_neg"}, a_neg, 0);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check({tag, "_idle"}, a_in_ready, 1);
  endtask

  task automatic run_b(input string tag, input logic [7:0] v, input logic [11:0] exp);
    int cyc;
    b_bin = v; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_bin = ~v;
    cyc = 0;
    while (!b_out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, "_lat"}, cyc, 8);
    check({tag, "_bcd"}, b_bcd, exp);
    check({tag, "_neg"}, b_neg, 0);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check({tag, "_idle"}, b_in_ready, 1);
  endtask

  task automatic run_c(input string tag, input logic [7:0] v, input logic [11:0] exp,
                       input logic exp_neg);
    int cyc;
    c_bin = v; c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_bin = ~v;
    cyc = 0;
    while (!c_out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, "_lat"}, cyc, 8);
    check({tag, "_bcd"}, c_bcd, exp);
    check({tag, "_neg"}, c_neg, exp_neg);
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] vals [100];
    int cyc, idx_in, res, last_cyc;
    logic prev_ready;

    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_bin = '0;
    b_in_valid = 0; b_out_ready = 0; b_bin = '0;
    c_in_valid = 0; c_out_ready = 0; c_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", b_in_ready, 0);
    check("rst_out_valid", b_out_valid, 0);
    check("rst_bcd", b_bcd, 0);
    check("rst_neg", c_neg, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready_a", a_in_ready, 1);
    check("post_rst_ready_b", b_in_ready, 1);

    run_b("b255", 8'd255, 12'h255);
    run_a("a65535", 16'd65535, 20'h65535);
    run_a("a0", 16'd0, 20'h00000);
    run_a("a1000", 16'd1000, 20'h01000);
    run_c("c7f", 8'h7F, 12'h127, 1'b0);
    run_c("c80", 8'h80, 12'h128, 1'b1);
    run_c("cff", 8'hFF, 12'h001, 1'b1);

    // Backpressure: hold DONE while a competing input is offered
    b_bin = 8'd99; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    cyc = 0;
    while (!b_out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("bp_lat", cyc, 8);
    b_in_valid = 1'b1; b_bin = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", b_out_valid, 1);
      check("bp_bcd", b_bcd, 12'h099);
      check("bp_in_ready", b_in_ready, 0);
    end
    b_out_ready = 1'b1; b_in_valid = 1'b0;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("bp_release_valid", b_out_valid, 0);
    check("bp_release_ready", b_in_ready, 1);
    check("bp_release_bcd", b_bcd, 12'h099);

    // Reset in the middle of a conversion
    b_bin = 8'd200; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", b_out_valid, 0);
    check("midrst_bcd", b_bcd, 0);
    check("midrst_in_ready", b_in_ready, 0);
    check("midrst_c_bcd", c_bcd, 0);
    check("midrst_c_neg", c_neg, 0);
    @(negedge clk);
    rst = 1'b0;
    run_b("b42", 8'd42, 12'h042);

    // Back-to-back stream with both handshakes tied high
    for (int i = 0; i < 100; i++) vals[i] = 8'($urandom_range(0, 255));
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_bin = vals[0];
    prev_ready = b_in_ready;
    idx_in = 0; res = 0; last_cyc = 0; cyc = 0;
    while (res < 100 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_ready) begin
        idx_in++;
        b_bin = (idx_in < 100) ? vals[idx_in] : 8'd0;
      end
      if (b_out_valid) begin
        check("b2b_bcd", b_bcd, ref_bcd(int'(vals[res])));
        if (res > 0) check("b2b_interval", cyc - last_cyc, 10);
        last_cyc = cyc;
        res++;
      end
      prev_ready = b_in_ready;
    end
    check("b2b_count", res, 100);
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
